// File: rtl/gpsdo_pkg.sv
// Shared definitions for the GPS-disciplined oscillator blocks: clock rate,
// default phase-word width and the phase-detector state encoding.
package gpsdo_pkg;

  localparam int CLK_HZ  = 10_000_000;
  localparam int PHASE_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LEAD_GPS   = 2'd1,
    ST_LEAD_LOCAL = 2'd2
  } pps_state_e;

endpackage

// File: rtl/pps_phase_detector_if.sv
// Result bundle of the 1PPS phase detector: offset samples, strobes and the
// GPS-presence level consumed by the discipline loop and the divider.
interface pps_phase_detector_if #(
  parameter int PHASE_W = gpsdo_pkg::PHASE_W
);
  import gpsdo_pkg::*;

  logic signed [PHASE_W-1:0] PHASE_ERR;
  logic                      PHASE_VALID;
  logic                      PHASE_TMO;
  logic                      DIV_RESET;
  logic                      GPS_LOST;

  modport master (
    output PHASE_ERR,
    output PHASE_VALID,
    output PHASE_TMO,
    output DIV_RESET,
    output GPS_LOST
  );

  modport slave (
    input PHASE_ERR,
    input PHASE_VALID,
    input PHASE_TMO,
    input DIV_RESET,
    input GPS_LOST
  );

endinterface

// File: rtl/pps_edge_sync.sv
// STAGES-deep synchronizer (SYNC_EN=1) or matched delay line (SYNC_EN=0)
// followed by a rising-edge detector; STAGES must be at least 2.
module pps_edge_sync #(
  parameter int STAGES  = 2,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_o
);

  logic lvl;
  logic prev_q, prev_d;

  if (SYNC_EN) begin : g_sync
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], din};

    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
    end

    assign lvl = sync_q[STAGES-1];
  end else begin : g_delay
    // Same depth as the synchronizer so both edges see identical latency.
    logic [STAGES-1:0] dly_q;
    logic [STAGES-1:0] dly_d;

    always_comb dly_d = {dly_q[STAGES-2:0], din};

    always_ff @(posedge clk) begin
      if (rst) dly_q <= '0;
      else     dly_q <= dly_d;
    end

    assign lvl = dly_q[STAGES-1];
  end

  always_comb prev_d = lvl;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign edge_o = lvl & ~prev_q;

endmodule

// File: rtl/pps_phase_detector.sv
// Measures the signed offset between GPS and local 1PPS in CLK_SYS cycles,
// requests a divider restart on persistent error and flags GPS loss.
module pps_phase_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int PHASE_W     = gpsdo_pkg::PHASE_W,
  parameter int MAX_WIN     = 5_000_000,
  parameter int RESYNC_TH   = 100,
  parameter int RESYNC_CNT  = 3,
  parameter int GPS_LOSS    = 15_000_000
) (
  input  logic                 CLK_SYS,
  input  logic                 CLK_RST,
  input  logic                 _1PPS_GPS,
  input  logic                 _1PPS_Local,
  pps_phase_detector_if.master res_if
);
  import gpsdo_pkg::*;

  localparam int LOSS_W = $clog2(GPS_LOSS + 1);
  localparam int BAD_W  = $clog2(RESYNC_CNT + 1);

  logic g_edge, l_edge;

  pps_state_e                state_q, state_d;
  logic [PHASE_W-1:0]        win_cnt_q, win_cnt_d;
  logic signed [PHASE_W-1:0] phase_err_q, phase_err_d;
  logic                      phase_valid_q, phase_valid_d;
  logic                      phase_tmo_q, phase_tmo_d;
  logic                      div_reset_q, div_reset_d;
  logic                      gps_lost_q, gps_lost_d;
  logic [BAD_W-1:0]          bad_cnt_q, bad_cnt_d;
  logic [LOSS_W-1:0]         loss_cnt_q, loss_cnt_d;

  logic               win_last;
  logic [PHASE_W-1:0] err_mag;
  logic [BAD_W-1:0]   bad_inc;
  logic               bad_evt, good_evt, resync;

  function automatic logic signed [PHASE_W-1:0] win_to_err(
    input logic [PHASE_W-1:0] cnt,
    input logic               neg
  );
    logic signed [PHASE_W-1:0] mag;
    mag = $signed(cnt + 1'b1);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [PHASE_W-1:0] err_abs(input logic signed [PHASE_W-1:0] v);
    return v[PHASE_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  pps_edge_sync #(.STAGES(SYNC_STAGES), .SYNC_EN(1'b1)) u_gps_sync (
    .clk    (CLK_SYS),
    .rst    (CLK_RST),
    .din    (_1PPS_GPS),
    .edge_o (g_edge)
  );

  pps_edge_sync #(.STAGES(SYNC_STAGES), .SYNC_EN(1'b0)) u_local_dly (
    .clk    (CLK_SYS),
    .rst    (CLK_RST),
    .din    (_1PPS_Local),
    .edge_o (l_edge)
  );

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q + 1'b1;
    phase_err_d   = phase_err_q;
    phase_valid_d = 1'b0;
    phase_tmo_d   = 1'b0;
    win_last      = (win_cnt_q == PHASE_W'(MAX_WIN - 1));

    case (state_q)
      ST_IDLE: begin
        win_cnt_d = '0;
        if (g_edge && l_edge) begin
          phase_err_d   = '0;
          phase_valid_d = 1'b1;
        end else if (g_edge) begin
          state_d = ST_LEAD_GPS;
        end else if (l_edge) begin
          state_d = ST_LEAD_LOCAL;
        end
      end
      ST_LEAD_GPS: begin
        if (l_edge) begin
          phase_err_d   = win_to_err(win_cnt_q, 1'b0);
          phase_valid_d = 1'b1;
          state_d       = ST_IDLE;
          win_cnt_d     = '0;
        end else if (g_edge) begin
          phase_tmo_d = 1'b1;
          win_cnt_d   = '0;
        end else if (win_last) begin
          phase_tmo_d = 1'b1;
          state_d     = ST_IDLE;
          win_cnt_d   = '0;
        end
      end
      ST_LEAD_LOCAL: begin
        if (g_edge) begin
          phase_err_d   = win_to_err(win_cnt_q, 1'b1);
          phase_valid_d = 1'b1;
          state_d       = ST_IDLE;
          win_cnt_d     = '0;
        end else if (l_edge) begin
          phase_tmo_d = 1'b1;
          win_cnt_d   = '0;
        end else if (win_last) begin
          phase_tmo_d = 1'b1;
          state_d     = ST_IDLE;
          win_cnt_d   = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        win_cnt_d = '0;
      end
    endcase

    // Quality judged on the published sample, so the threshold itself is good.
    err_mag  = err_abs(phase_err_q);
    bad_evt  = (phase_valid_q && (err_mag > PHASE_W'(RESYNC_TH))) || phase_tmo_q;
    good_evt = phase_valid_q && (err_mag <= PHASE_W'(RESYNC_TH));
    bad_inc  = bad_cnt_q + 1'b1;
    resync   = bad_evt && !gps_lost_q && (bad_inc == BAD_W'(RESYNC_CNT));

    if (gps_lost_q || resync) bad_cnt_d = '0;
    else if (bad_evt)         bad_cnt_d = bad_inc;
    else if (good_evt)        bad_cnt_d = '0;
    else                      bad_cnt_d = bad_cnt_q;

    div_reset_d = resync;
    if (resync) begin
      state_d   = ST_IDLE;
      win_cnt_d = '0;
    end

    if (g_edge)                                   loss_cnt_d = '0;
    else if (loss_cnt_q == LOSS_W'(GPS_LOSS))     loss_cnt_d = loss_cnt_q;
    else                                          loss_cnt_d = loss_cnt_q + 1'b1;
    gps_lost_d = (loss_cnt_d == LOSS_W'(GPS_LOSS));
  end

  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state_q       <= ST_IDLE;
      win_cnt_q     <= '0;
      phase_err_q   <= '0;
      phase_valid_q <= 1'b0;
      phase_tmo_q   <= 1'b0;
      div_reset_q   <= 1'b0;
      gps_lost_q    <= 1'b0;
      bad_cnt_q     <= '0;
      loss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      phase_err_q   <= phase_err_d;
      phase_valid_q <= phase_valid_d;
      phase_tmo_q   <= phase_tmo_d;
      div_reset_q   <= div_reset_d;
      gps_lost_q    <= gps_lost_d;
      bad_cnt_q     <= bad_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
    end
  end

  assign res_if.PHASE_ERR   = phase_err_q;
  assign res_if.PHASE_VALID = phase_valid_q;
  assign res_if.PHASE_TMO   = phase_tmo_q;
  assign res_if.DIV_RESET   = div_reset_q;
  assign res_if.GPS_LOST    = gps_lost_q;

endmodule
